// File: rtl/fsr_pkg.sv
// Shared definitions for the FSR pointer bank: indirect-access mode encoding
// and the helper that sizes the channel-select ports.
package fsr_pkg;

   typedef enum logic [1:0] {
      IND_NONE    = 2'd0,
      IND_POSTINC = 2'd1,
      IND_POSTDEC = 2'd2,
      IND_PREINC  = 2'd3
   } ind_mode_t;

   // Select width for a bank of n channels; a single channel still gets a 1-bit select.
   function automatic int sel_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fsr_channel.sv
// One FSR channel: live pointer, shadow copy and sticky wrap bit, with the
// increment/decrement logic used by indirect accesses.
module fsr_channel
   import fsr_pkg::*;
#(
   parameter int FSR_W = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             restore,
   input  logic             save,
   input  logic             load,
   input  logic [FSR_W-1:0] data_in,
   input  logic             step,
   input  ind_mode_t        mode,
   output logic [FSR_W-1:0] value,
   output logic             wrap
);

   logic [FSR_W-1:0] shadow;
   logic [FSR_W-1:0] step_value;
   logic             step_wraps;

   // Post-access pointer value and whether that access rolls over the pointer range.
   always_comb begin
      step_value = value;
      step_wraps = 1'b0;
      case (mode)
         IND_POSTINC, IND_PREINC: begin
            step_value = value + FSR_W'(1);
            step_wraps = (value == '1);
         end
         IND_POSTDEC: begin
            step_value = value - FSR_W'(1);
            step_wraps = (value == '0);
         end
         default: begin
            step_value = value;
            step_wraps = 1'b0;
         end
      endcase
   end

   // Register update: restore beats direct load, which beats the indirect step; save samples the pre-edge value.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         value  <= '0;
         shadow <= '0;
         wrap   <= 1'b0;
      end else if (restore) begin
         value <= shadow;
         wrap  <= 1'b0;
      end else begin
         if (save) begin
            shadow <= value;
         end
         if (load) begin
            value <= data_in;
            wrap  <= 1'b0;
         end else if (step) begin
            value <= step_value;
            if (step_wraps) begin
               wrap <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fsr_bank.sv
// Bank of N_CH indirect-addressing pointer registers with direct read/write,
// combinational indirect address generation and a shared save/restore shadow set.
module fsr_bank
   import fsr_pkg::*;
#(
   parameter int N_CH   = 2,
   parameter int FSR_W  = 8,
   parameter int ADDR_W = 5
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [sel_width(N_CH)-1:0]  sel,
   input  logic                        write_en,
   input  logic                        out_en,
   input  logic [FSR_W-1:0]            data_in,
   output logic [FSR_W-1:0]            data_out,
   input  logic                        ind_en,
   input  logic [sel_width(N_CH)-1:0]  ind_sel,
   input  logic [1:0]                  ind_mode,
   output logic [ADDR_W-1:0]           ind_addr,
   output logic [N_CH-1:0]             wrap_flag,
   input  logic                        save,
   input  logic                        restore
);

   logic [FSR_W-1:0] ch_value [N_CH];
   logic [FSR_W-1:0] rd_value;
   logic [FSR_W-1:0] ind_value;
   logic [FSR_W-1:0] ind_target;
   logic             sel_ok;
   logic             ind_ok;
   ind_mode_t        mode;

   assign mode = ind_mode_t'(ind_mode);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      fsr_channel #(
         .FSR_W (FSR_W)
      ) u_channel (
         .clock   (clock),
         .reset_n (reset_n),
         .restore (restore),
         .save    (save),
         .load    (write_en && (int'(sel) == i)),
         .data_in (data_in),
         .step    (ind_en && (int'(ind_sel) == i)),
         .mode    (mode),
         .value   (ch_value[i]),
         .wrap    (wrap_flag[i])
      );
   end

   // Pick the directly and indirectly selected channels; out-of-range selects read as zero.
   always_comb begin
      rd_value  = '0;
      ind_value = '0;
      sel_ok    = (int'(sel) < N_CH);
      ind_ok    = (int'(ind_sel) < N_CH);
      for (int i = 0; i < N_CH; i++) begin
         if (int'(sel) == i) begin
            rd_value = ch_value[i];
         end
         if (int'(ind_sel) == i) begin
            ind_value = ch_value[i];
         end
      end
   end

   // Effective indirect address: pre-increment looks one ahead, everything else uses the current pointer.
   always_comb begin
      ind_target = (mode == IND_PREINC) ? (ind_value + FSR_W'(1)) : ind_value;
      if (reset_n && ind_ok) begin
         ind_addr = ADDR_W'(ind_target);
      end else begin
         ind_addr = '0;
      end
   end

   assign data_out = out_en ? ((reset_n && sel_ok) ? rd_value : '0) : 'z;

endmodule

// File: tb/tb_fsr_bank.sv
// Directed bench for fsr_bank: a cycle-by-cycle vector table plus hand-written
// reset-during-burst and shadow-clear sequences.
module tb_fsr_bank;
   import fsr_pkg::*;

   localparam int N_CH   = 3;
   localparam int FSR_W  = 8;
   localparam int ADDR_W = 5;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic [1:0]       sel = '0;
   logic             write_en = 1'b0;
   logic             out_en = 1'b0;
   logic [FSR_W-1:0] data_in = '0;
   wire  [FSR_W-1:0] data_out;
   logic             ind_en = 1'b0;
   logic [1:0]       ind_sel = '0;
   logic [1:0]       ind_mode = '0;
   wire  [ADDR_W-1:0] ind_addr;
   wire  [N_CH-1:0]  wrap_flag;
   logic             save = 1'b0;
   logic             restore = 1'b0;

   int tests_run = 0;
   int failures  = 0;

   typedef struct {
      logic             we;
      logic [1:0]       sel;
      logic [7:0]       din;
      logic             ie;
      logic [1:0]       isel;
      logic [1:0]       mode;
      logic             sv;
      logic             rs;
      logic [7:0]       exp_dout;
      logic [4:0]       exp_iaddr;
      logic [2:0]       exp_wrap;
   } vec_t;

   vec_t vecs[$];

   fsr_bank #(
      .N_CH   (N_CH),
      .FSR_W  (FSR_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .sel       (sel),
      .write_en  (write_en),
      .out_en    (out_en),
      .data_in   (data_in),
      .data_out  (data_out),
      .ind_en    (ind_en),
      .ind_sel   (ind_sel),
      .ind_mode  (ind_mode),
      .ind_addr  (ind_addr),
      .wrap_flag (wrap_flag),
      .save      (save),
      .restore   (restore)
   );

   always #5 clock = ~clock;

   task automatic addVec(input logic we, input logic [1:0] s, input logic [7:0] din,
                         input logic ie, input logic [1:0] isel, input logic [1:0] mode,
                         input logic sv, input logic rs, input logic [7:0] exp_dout,
                         input logic [4:0] exp_iaddr, input logic [2:0] exp_wrap);
      vec_t v;
      v.we = we; v.sel = s; v.din = din; v.ie = ie; v.isel = isel; v.mode = mode;
      v.sv = sv; v.rs = rs; v.exp_dout = exp_dout; v.exp_iaddr = exp_iaddr;
      v.exp_wrap = exp_wrap;
      vecs.push_back(v);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      reset_n  = 1'b1;
      out_en   = 1'b1;
      write_en = v.we;
      sel      = v.sel;
      data_in  = v.din;
      ind_en   = v.ie;
      ind_sel  = v.isel;
      ind_mode = v.mode;
      save     = v.sv;
      restore  = v.rs;
   endtask

   task automatic idle();
      reset_n  = 1'b1;
      out_en   = 1'b1;
      write_en = 1'b0;
      ind_en   = 1'b0;
      ind_mode = IND_NONE;
      save     = 1'b0;
      restore  = 1'b0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Reset with a pending pre-increment: address and data must read zero throughout.
      reset_n = 1'b0; out_en = 1'b1; sel = 2'd0;
      ind_en = 1'b1; ind_sel = 2'd0; ind_mode = IND_PREINC;
      tick();
      #1;
      checkOutput("reset_iaddr", 32'(ind_addr), 32'h00);
      checkOutput("reset_dout", 32'(data_out), 32'h00);
      tick();
      idle();
      #1;
      checkOutput("post_reset_wrap", 32'(wrap_flag), 32'h0);
      checkOutput("post_reset_dout", 32'(data_out), 32'h00);
      checkOutput("post_reset_iaddr", 32'(ind_addr), 32'h00);

      // Outputs listed are the pre-edge values of each row's cycle.
      //     we sel din    ie isel mode         sv rs  dout   iaddr  wrap
      addVec(1, 0, 8'h1F, 0, 0, IND_NONE,    0, 0, 8'h00, 5'h00, 3'b000);
      addVec(0, 0, 8'h00, 1, 0, IND_NONE,    0, 0, 8'h1F, 5'h1F, 3'b000);
      addVec(1, 1, 8'hFF, 0, 0, IND_NONE,    0, 0, 8'h00, 5'h1F, 3'b000);
      addVec(0, 1, 8'h00, 1, 1, IND_POSTINC, 0, 0, 8'hFF, 5'h1F, 3'b000);
      addVec(0, 1, 8'h00, 0, 1, IND_NONE,    0, 0, 8'h00, 5'h00, 3'b010);
      addVec(1, 1, 8'h07, 0, 1, IND_NONE,    0, 0, 8'h00, 5'h00, 3'b010);
      addVec(0, 1, 8'h00, 0, 1, IND_NONE,    0, 0, 8'h07, 5'h07, 3'b000);
      addVec(1, 0, 8'h10, 0, 0, IND_NONE,    0, 0, 8'h1F, 5'h1F, 3'b000);
      addVec(0, 0, 8'h00, 1, 0, IND_PREINC,  0, 0, 8'h10, 5'h11, 3'b000);
      addVec(0, 0, 8'h00, 1, 0, IND_POSTDEC, 0, 0, 8'h11, 5'h11, 3'b000);
      addVec(0, 0, 8'h00, 0, 0, IND_NONE,    0, 0, 8'h10, 5'h10, 3'b000);
      addVec(1, 0, 8'h40, 0, 0, IND_NONE,    0, 0, 8'h10, 5'h10, 3'b000);
      addVec(1, 0, 8'h05, 1, 0, IND_POSTINC, 0, 0, 8'h40, 5'h00, 3'b000);
      addVec(0, 0, 8'h00, 0, 0, IND_NONE,    0, 0, 8'h05, 5'h05, 3'b000);
      addVec(1, 2, 8'hFF, 0, 2, IND_NONE,    0, 0, 8'h00, 5'h00, 3'b000);
      addVec(1, 2, 8'h33, 1, 2, IND_POSTINC, 0, 0, 8'hFF, 5'h1F, 3'b000);
      addVec(0, 2, 8'h00, 0, 2, IND_NONE,    0, 0, 8'h33, 5'h13, 3'b000);
      addVec(1, 1, 8'h80, 1, 0, IND_POSTDEC, 0, 0, 8'h07, 5'h05, 3'b000);
      addVec(0, 0, 8'h00, 0, 1, IND_NONE,    0, 0, 8'h04, 5'h00, 3'b000);
      addVec(1, 0, 8'h00, 0, 0, IND_NONE,    0, 0, 8'h04, 5'h04, 3'b000);
      addVec(0, 0, 8'h00, 1, 0, IND_POSTDEC, 0, 0, 8'h00, 5'h00, 3'b000);
      addVec(0, 0, 8'h00, 0, 0, IND_NONE,    0, 0, 8'hFF, 5'h1F, 3'b001);
      addVec(1, 0, 8'h20, 0, 0, IND_NONE,    0, 0, 8'hFF, 5'h1F, 3'b001);
      addVec(1, 1, 8'h30, 0, 1, IND_NONE,    0, 0, 8'h80, 5'h00, 3'b000);
      addVec(1, 0, 8'h99, 0, 0, IND_NONE,    1, 0, 8'h20, 5'h00, 3'b000);
      addVec(0, 0, 8'h00, 1, 1, IND_POSTINC, 0, 0, 8'h99, 5'h10, 3'b000);
      addVec(1, 2, 8'hFF, 0, 2, IND_NONE,    0, 0, 8'h33, 5'h13, 3'b000);
      addVec(0, 2, 8'h00, 1, 2, IND_POSTINC, 0, 0, 8'hFF, 5'h1F, 3'b000);
      addVec(1, 0, 8'h55, 1, 1, IND_POSTINC, 1, 1, 8'h99, 5'h11, 3'b100);
      addVec(0, 0, 8'h00, 0, 1, IND_NONE,    0, 0, 8'h20, 5'h10, 3'b000);
      addVec(0, 1, 8'h00, 0, 2, IND_NONE,    0, 0, 8'h30, 5'h13, 3'b000);
      addVec(0, 2, 8'h00, 0, 0, IND_NONE,    0, 0, 8'h33, 5'h00, 3'b000);
      addVec(1, 0, 8'h77, 0, 0, IND_NONE,    0, 0, 8'h20, 5'h00, 3'b000);
      addVec(0, 0, 8'h00, 0, 0, IND_NONE,    0, 1, 8'h77, 5'h17, 3'b000);
      addVec(0, 0, 8'h00, 0, 1, IND_NONE,    0, 0, 8'h20, 5'h10, 3'b000);
      addVec(1, 3, 8'hAA, 1, 3, IND_POSTINC, 0, 0, 8'h00, 5'h00, 3'b000);
      addVec(0, 0, 8'h00, 0, 1, IND_NONE,    0, 0, 8'h20, 5'h10, 3'b000);
      addVec(0, 2, 8'h00, 0, 2, IND_PREINC,  0, 0, 8'h33, 5'h14, 3'b000);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("vec%0d_dout", i), 32'(data_out), 32'(vecs[i].exp_dout));
         checkOutput($sformatf("vec%0d_iaddr", i), 32'(ind_addr), 32'(vecs[i].exp_iaddr));
         checkOutput($sformatf("vec%0d_wrap", i), 32'(wrap_flag), 32'(vecs[i].exp_wrap));
         tick();
      end

      // Channels now hold 0x20/0x30/0x33 with matching shadows; build a wrap, then burst and reset.
      idle();
      write_en = 1'b1; sel = 2'd1; data_in = 8'hFF;
      tick();
      idle();
      ind_en = 1'b1; ind_sel = 2'd1; ind_mode = IND_POSTINC;
      tick();
      idle();
      ind_en = 1'b1; ind_sel = 2'd0; ind_mode = IND_POSTINC; sel = 2'd0;
      #1;
      checkOutput("burst_wrap", 32'(wrap_flag), 32'h2);
      checkOutput("burst0_iaddr", 32'(ind_addr), 32'h00);
      tick();
      #1;
      checkOutput("burst1_iaddr", 32'(ind_addr), 32'h01);
      tick();
      reset_n = 1'b0;
      #1;
      checkOutput("burst_rst_iaddr", 32'(ind_addr), 32'h00);
      checkOutput("burst_rst_dout", 32'(data_out), 32'h00);
      tick();
      idle();
      ind_sel = 2'd0;
      #1;
      checkOutput("after_rst_wrap", 32'(wrap_flag), 32'h0);
      checkOutput("after_rst_iaddr", 32'(ind_addr), 32'h00);
      for (int c = 0; c < N_CH; c++) begin
         sel = 2'(c);
         #1;
         checkOutput($sformatf("after_rst_ch%0d", c), 32'(data_out), 32'h00);
      end

      // Shadows must also have been cleared by the reset.
      write_en = 1'b1; sel = 2'd0; data_in = 8'h5B;
      tick();
      idle();
      sel = 2'd0;
      #1;
      checkOutput("pre_restore_ch0", 32'(data_out), 32'h5B);
      restore = 1'b1;
      tick();
      idle();
      for (int c = 0; c < N_CH; c++) begin
         sel = 2'(c);
         #1;
         checkOutput($sformatf("shadow_clr_ch%0d", c), 32'(data_out), 32'h00);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
